// File: rtl/xiphy_dly_tap_pkg.sv
// Shared types for the bitslice delay-tap sequencer: op codes, FSM states and the clamp helper.
package xiphy_dly_tap_pkg;

   localparam int TAP_W = 9;

   typedef enum logic [1:0] {
      OP_INC  = 2'b00,
      OP_DEC  = 2'b01,
      OP_LOAD = 2'b10,
      OP_READ = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_VTC_OFF,
      ST_PRE_SAMPLE,
      ST_ACT,
      ST_POST_SAMPLE,
      ST_RESP
   } state_e;

   typedef struct packed {
      logic [TAP_W-1:0] amt;
      logic             err;
   } clamp_t;

   // Step count (INC/DEC) or load target (LOAD), limited by the delay-line range.
   function automatic clamp_t clamp_req(op_e op, logic [TAP_W-1:0] req,
                                        logic [TAP_W-1:0] cur, logic [TAP_W:0] tap_max);
      logic [TAP_W:0] req10;
      logic [TAP_W:0] cur10;
      logic [TAP_W:0] lim;
      clamp_t         r;
      req10 = {1'b0, req};
      cur10 = {1'b0, cur};
      case (op)
         OP_INC:  lim = (cur10 >= tap_max) ? '0 : tap_max - cur10;
         OP_DEC:  lim = cur10;
         default: lim = tap_max;
      endcase
      r.err = (op != OP_READ) && (req10 > lim);
      r.amt = (req10 > lim) ? lim[TAP_W-1:0] : req;
      return r;
   endfunction

endpackage

// File: rtl/xiphy_dly_wait_cnt.sv
// Loadable down-counter; done is high while the count sits at zero.
// Loading N-1 makes done rise in the Nth cycle after the load edge.
module xiphy_dly_wait_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/xiphy_dly_tap_ctrl.sv
// Turns one calibration request into a legal ce/inc/ld/en_vtc sequence on a bitslice delay line.
// One request outstanding; req_ready is high only in IDLE and rsp_valid pulses once per request.
module xiphy_dly_tap_ctrl
   import xiphy_dly_tap_pkg::*;
#(
   parameter int VTC_SETTLE_CYC = 16,
   parameter int STEP_GAP_CYC   = 4,
   parameter int SAMPLE_CYC     = 3,
   parameter int IDLE_VTC_CYC   = 64,
   parameter int TAP_MAX        = 511
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [TAP_W-1:0] req_val,
   output logic             rsp_valid,
   output logic [TAP_W-1:0] rsp_cntvalue,
   output logic             rsp_err,
   output logic             dly_ce,
   output logic             dly_inc,
   output logic             dly_ld,
   output logic [TAP_W-1:0] dly_cntvaluein,
   output logic             dly_en_vtc,
   input  logic [TAP_W-1:0] dly_cntvalueout
);

   localparam int MAX_A    = (VTC_SETTLE_CYC > STEP_GAP_CYC) ? VTC_SETTLE_CYC : STEP_GAP_CYC;
   localparam int MAX_B    = (SAMPLE_CYC > IDLE_VTC_CYC) ? SAMPLE_CYC : IDLE_VTC_CYC;
   localparam int WAIT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

   localparam logic [WAIT_W-1:0] SETTLE_LD = WAIT_W'(VTC_SETTLE_CYC - 1);
   localparam logic [WAIT_W-1:0] GAP_LD    = WAIT_W'(STEP_GAP_CYC - 1);
   localparam logic [WAIT_W-1:0] SAMPLE_LD = WAIT_W'(SAMPLE_CYC - 1);
   localparam logic [WAIT_W-1:0] IDLE_LD   = WAIT_W'(IDLE_VTC_CYC - 1);

   state_e           state;
   op_e              op_q;
   logic [TAP_W-1:0] val_q;
   logic [TAP_W-1:0] rem_q;
   logic             err_q;

   logic              accept;
   logic              is_step;
   logic              act_last;
   clamp_t            clamp;
   logic              wait_load;
   logic [WAIT_W-1:0] wait_val;
   logic              wait_done;

   assign accept   = req_valid & req_ready;
   assign is_step  = (op_q == OP_INC) || (op_q == OP_DEC);
   assign act_last = is_step ? (dly_ce && (rem_q == '0)) : dly_ld;
   assign clamp    = clamp_req(op_q, val_q, dly_cntvalueout, (TAP_W+1)'(TAP_MAX));

   // One timer serves settle, step gap, sample and idle windows; reload points follow the FSM edges.
   always_comb begin
      wait_load = 1'b0;
      wait_val  = '0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               wait_load = 1'b1;
               wait_val  = dly_en_vtc ? SETTLE_LD : '0;
            end
         end
         ST_VTC_OFF: begin
            if (wait_done) begin
               wait_load = 1'b1;
               wait_val  = SAMPLE_LD;
            end
         end
         ST_PRE_SAMPLE: begin
            if (wait_done && is_step) begin
               wait_load = 1'b1;
               wait_val  = (clamp.amt == '0) ? SAMPLE_LD : GAP_LD;
            end
         end
         ST_ACT: begin
            if (act_last) begin
               wait_load = 1'b1;
               wait_val  = SAMPLE_LD;
            end else if (is_step && !dly_ce && wait_done) begin
               wait_load = 1'b1;
               wait_val  = GAP_LD;
            end
         end
         ST_RESP: begin
            wait_load = 1'b1;
            wait_val  = IDLE_LD;
         end
         default: ;
      endcase
   end

   xiphy_dly_wait_cnt #(.W(WAIT_W)) u_wait (
      .clk      (clk),
      .rst      (rst),
      .load     (wait_load),
      .load_val (wait_val),
      .done     (wait_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_IDLE;
         op_q           <= OP_INC;
         val_q          <= '0;
         rem_q          <= '0;
         err_q          <= 1'b0;
         req_ready      <= 1'b0;
         rsp_valid      <= 1'b0;
         rsp_cntvalue   <= '0;
         rsp_err        <= 1'b0;
         dly_ce         <= 1'b0;
         dly_inc        <= 1'b0;
         dly_ld         <= 1'b0;
         dly_cntvaluein <= '0;
         dly_en_vtc     <= 1'b1;
      end else begin
         rsp_valid <= 1'b0;
         dly_ce    <= 1'b0;
         dly_ld    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state      <= ST_VTC_OFF;
                  req_ready  <= 1'b0;
                  op_q       <= op_e'(req_op);
                  val_q      <= req_val;
                  dly_en_vtc <= 1'b0;
               end else begin
                  req_ready <= 1'b1;
                  if (!dly_en_vtc && wait_done) begin
                     dly_en_vtc <= 1'b1;
                  end
               end
            end
            ST_VTC_OFF: begin
               if (wait_done) begin
                  state <= ST_PRE_SAMPLE;
               end
            end
            ST_PRE_SAMPLE: begin
               if (wait_done) begin
                  err_q <= clamp.err;
                  if (op_q == OP_READ) begin
                     state        <= ST_RESP;
                     rsp_valid    <= 1'b1;
                     rsp_cntvalue <= dly_cntvalueout;
                     rsp_err      <= 1'b0;
                  end else if (op_q == OP_LOAD) begin
                     state          <= ST_ACT;
                     dly_cntvaluein <= clamp.amt;
                  end else if (clamp.amt == '0) begin
                     state <= ST_POST_SAMPLE;
                  end else begin
                     state   <= ST_ACT;
                     dly_inc <= (op_q == OP_INC);
                     dly_ce  <= 1'b1;
                     rem_q   <= clamp.amt - TAP_W'(1);
                  end
               end
            end
            ST_ACT: begin
               if (act_last) begin
                  state          <= ST_POST_SAMPLE;
                  dly_inc        <= 1'b0;
                  dly_cntvaluein <= '0;
               end else if (!is_step) begin
                  dly_ld <= 1'b1;
               end else if (!dly_ce && wait_done) begin
                  dly_ce <= 1'b1;
                  rem_q  <= rem_q - TAP_W'(1);
               end
            end
            ST_POST_SAMPLE: begin
               if (wait_done) begin
                  state        <= ST_RESP;
                  rsp_valid    <= 1'b1;
                  rsp_cntvalue <= dly_cntvalueout;
                  rsp_err      <= err_q;
               end
            end
            ST_RESP: begin
               state     <= ST_IDLE;
               req_ready <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_xiphy_dly_tap_ctrl.sv
// Bench for xiphy_dly_tap_ctrl: behavioural delay line plus directed table, reset-abort and random requests.
module tb_xiphy_dly_tap_ctrl;

   localparam int SETTLE = 16;
   localparam int GAP    = 4;
   localparam int SAMP   = 3;
   localparam int IDLEV  = 64;
   localparam int TMAX   = 511;

   localparam logic [1:0] OPI = 2'b00;
   localparam logic [1:0] OPD = 2'b01;
   localparam logic [1:0] OPL = 2'b10;
   localparam logic [1:0] OPR = 2'b11;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [1:0] req_op = 2'b00;
   logic [8:0] req_val = '0;
   logic       rsp_valid;
   logic [8:0] rsp_cntvalue;
   logic       rsp_err;
   logic       dly_ce;
   logic       dly_inc;
   logic       dly_ld;
   logic [8:0] dly_cntvaluein;
   logic       dly_en_vtc;
   logic [8:0] dly_cntvalueout;

   always #5 clk = ~clk;

   xiphy_dly_tap_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_op          (req_op),
      .req_val         (req_val),
      .rsp_valid       (rsp_valid),
      .rsp_cntvalue    (rsp_cntvalue),
      .rsp_err         (rsp_err),
      .dly_ce          (dly_ce),
      .dly_inc         (dly_inc),
      .dly_ld          (dly_ld),
      .dly_cntvaluein  (dly_cntvaluein),
      .dly_en_vtc      (dly_en_vtc),
      .dly_cntvalueout (dly_cntvalueout)
   );

   // Delay line: keeps its tap value across controller reset.
   logic [8:0] line = '0;
   logic       preset_en = 1'b0;
   logic [8:0] preset_val = '0;
   assign dly_cntvalueout = line;

   always @(posedge clk) begin
      if (preset_en)   line <= preset_val;
      else if (dly_ld) line <= dly_cntvaluein;
      else if (dly_ce) line <= dly_inc ? ((line == 9'd511) ? line : line + 9'd1)
                                       : ((line == 9'd0) ? line : line - 9'd1);
   end

   int         n_cmp = 0;
   int         n_bad = 0;
   bit         vtc_on = 1'b1;
   int         idle_j = 0;
   logic [8:0] last_rsp = '0;
   bit         last_err = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Idle cycles; en_vtc should return only after more than IDLEV idle cycles.
   task automatic idle_cyc(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         idle_j++;
         if (idle_j > IDLEV) vtc_on = 1'b1;
         check("idle_en_vtc", dly_en_vtc, vtc_on);
         check("idle_quiet", {dly_ce, dly_ld, dly_inc, rsp_valid, ~req_ready}, 0);
         check("rsp_hold", {rsp_err, rsp_cntvalue}, {last_err, last_rsp});
      end
   endtask

   task automatic preset(input logic [8:0] v);
      preset_val = v;
      preset_en  = 1'b1;
      idle_cyc(1);
      preset_en  = 1'b0;
   endtask

   // Reference: expected steps, read-back and clamp flag from the target tap value.
   function automatic void ref_model(input logic [1:0] op, input int val, input int cur,
                                     output int n, output int rsp, output bit err);
      n = 0; rsp = cur; err = 1'b0;
      case (op)
         OPI: if (cur + val > TMAX) begin n = TMAX - cur; rsp = TMAX; err = 1'b1; end
              else begin n = val; rsp = cur + val; end
         OPD: if (val > cur) begin n = cur; rsp = 0; err = 1'b1; end
              else begin n = val; rsp = cur - val; end
         OPL: if (val > TMAX) begin rsp = TMAX; err = 1'b1; end
              else rsp = val;
         default: rsp = cur;
      endcase
   endfunction

   task automatic run_req(input logic [1:0] op, input logic [8:0] val,
                          input int exp_pulses, input int exp_rsp, input bit exp_err);
      int settle, f, rsp_k, k, pulses, lds, last_p;
      bit inv_bad, timing_bad, got, exp_inc;
      settle = vtc_on ? SETTLE : 1;
      f      = 1 + settle + SAMP;
      last_p = f + (exp_pulses - 1) * GAP;
      case (op)
         OPR:     rsp_k = f;
         OPL:     rsp_k = f + 2 + SAMP;
         default: rsp_k = (exp_pulses == 0) ? f + SAMP : last_p + SAMP + 1;
      endcase
      check("ready_before", req_ready, 1);
      req_valid = 1'b1;
      req_op    = op;
      req_val   = val;
      tick();
      req_valid = 1'b0;
      req_op    = 2'b00;
      req_val   = '0;
      check("vtc_drop", dly_en_vtc, 0);
      check("ready_drop", req_ready, 0);
      k = 1; pulses = 0; lds = 0; got = 0; inv_bad = 0; timing_bad = 0;
      while (k <= 6000) begin
         exp_inc = (op == OPI) && (exp_pulses > 0) && (k >= f) && (k <= last_p);
         if (dly_ce && dly_ld) inv_bad = 1;
         if (dly_en_vtc || req_ready) inv_bad = 1;
         if (dly_inc != exp_inc) inv_bad = 1;
         if (!rsp_valid && ({rsp_err, rsp_cntvalue} != {last_err, last_rsp})) inv_bad = 1;
         if (dly_ce) begin
            if (k != f + pulses * GAP) timing_bad = 1;
            pulses++;
         end
         if (op == OPL && k == f && dly_cntvaluein != exp_rsp[8:0]) timing_bad = 1;
         if (dly_ld) begin
            if (k != f + 1 || dly_cntvaluein != exp_rsp[8:0]) timing_bad = 1;
            lds++;
         end
         if (rsp_valid) begin
            got = 1;
            break;
         end
         tick();
         k++;
      end
      check("rsp_seen", got, 1);
      check("rsp_cycle", k, rsp_k);
      check("rsp_value", rsp_cntvalue, exp_rsp);
      check("rsp_err", rsp_err, exp_err);
      check("ce_count", pulses, exp_pulses);
      check("ld_count", lds, (op == OPL) ? 1 : 0);
      check("pulse_timing", timing_bad, 0);
      check("ctrl_rules", inv_bad, 0);
      vtc_on   = 1'b0;
      idle_j   = 0;
      last_rsp = exp_rsp[8:0];
      last_err = exp_err;
   endtask

   typedef struct {
      bit         do_preset;
      logic [8:0] preset;
      int         idle_before;
      logic [1:0] op;
      logic [8:0] val;
      int         exp_pulses;
      int         exp_rsp;
      bit         exp_err;
   } vec_t;

   vec_t vecs[7];
   int   gaps[7];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int ces;
      vecs[0] = '{1'b1, 9'd100, 2,  OPI, 9'd5,   5, 105, 1'b0};
      vecs[1] = '{1'b1, 9'd508, 2,  OPI, 9'd10,  3, 511, 1'b1};
      vecs[2] = '{1'b1, 9'd2,   2,  OPD, 9'd7,   2, 0,   1'b1};
      vecs[3] = '{1'b0, 9'd0,   3,  OPL, 9'd300, 0, 300, 1'b0};
      vecs[4] = '{1'b0, 9'd0,   10, OPR, 9'd0,   0, 300, 1'b0};
      vecs[5] = '{1'b0, 9'd0,   64, OPR, 9'd0,   0, 300, 1'b0};
      vecs[6] = '{1'b0, 9'd0,   65, OPR, 9'd0,   0, 300, 1'b0};
      gaps[0] = 1; gaps[1] = 2; gaps[2] = 5; gaps[3] = 63;
      gaps[4] = 64; gaps[5] = 65; gaps[6] = 70;

      // Reset state and release.
      tick(); tick();
      check("reset_outs", {req_ready, rsp_valid, rsp_cntvalue, rsp_err, dly_ce, dly_inc,
                           dly_ld, dly_cntvaluein, dly_en_vtc}, 1);
      rst = 1'b0;
      #1;
      check("ready_before_edge", req_ready, 0);
      tick();
      check("ready_first_edge", req_ready, 1);
      check("vtc_first_edge", dly_en_vtc, 1);
      idle_cyc(IDLEV + 6);

      for (int i = 0; i < 7; i++) begin
         if (vecs[i].do_preset) preset(vecs[i].preset);
         idle_cyc(vecs[i].idle_before);
         run_req(vecs[i].op, vecs[i].val, vecs[i].exp_pulses, vecs[i].exp_rsp, vecs[i].exp_err);
      end

      // Reset during the 3rd INC pulse: two steps land, no response.
      idle_cyc(70);
      preset(9'd200);
      idle_cyc(1);
      req_valid = 1'b1; req_op = OPI; req_val = 9'd5;
      tick();
      req_valid = 1'b0; req_op = 2'b00; req_val = '0;
      ces = 0;
      for (int k = 0; k < 200 && ces < 3; k++) begin
         if (dly_ce) ces++;
         if (ces < 3) tick();
      end
      check("abort_reached_3rd_ce", ces, 3);
      #1;
      rst = 1'b1;
      #1;
      check("abort_async_reset", {req_ready, rsp_valid, rsp_cntvalue, rsp_err, dly_ce, dly_inc,
                                  dly_ld, dly_cntvaluein, dly_en_vtc}, 1);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("abort_no_rsp", rsp_valid, 0);
      end
      rst = 1'b0;
      tick();
      check("abort_ready", req_ready, 1);
      vtc_on = 1'b1; idle_j = 0; last_rsp = '0; last_err = 1'b0;
      idle_cyc(5);
      run_req(OPR, 9'd0, 0, 202, 1'b0);

      // Randomized requests against the reference model.
      for (int it = 0; it < 30; it++) begin
         int         n, r, sel;
         bit         e;
         logic [1:0] op;
         logic [8:0] v;
         op = 2'($urandom_range(0, 3));
         if (op == OPL) begin
            sel = $urandom_range(0, 2);
            v = (sel == 0) ? 9'($urandom_range(0, 6)) :
                (sel == 1) ? 9'($urandom_range(505, 511)) : 9'($urandom_range(0, 511));
         end else begin
            v = 9'($urandom_range(0, 15));
         end
         idle_cyc(gaps[$urandom_range(0, 6)]);
         ref_model(op, int'(v), int'(line), n, r, e);
         run_req(op, v, n, r, e);
      end
      idle_cyc(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
